// File: rtl/id_pkg.sv
// Shared decode-stage definitions: opcode constants, immediate-extension
// encodings, hazard FSM state encoding and the ext_mode decode helper.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // 2'b11 is reserved and never produced by the decoder.
    typedef enum logic [1:0] {
        EXT_SIGN = 2'b00,
        EXT_ZERO = 2'b01,
        EXT_LUI  = 2'b10
    } ext_mode_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hz_state_e;

    // Logical immediates are zero-extended, lui shifts into the upper half,
    // everything else (arithmetic, loads, stores, branches) sign-extends.
    function automatic logic [1:0] decode_ext_mode(input logic [5:0] op);
        logic [1:0] mode;
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: mode = EXT_ZERO;
            OP_LUI:                   mode = EXT_LUI;
            default:                  mode = EXT_SIGN;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/id_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: compares the ID-stage source
// registers against the destination of a load sitting in EX.
module load_use_detect
    import id_pkg::*;
(
    input  logic       instr_valid,
    input  logic [5:0] opcode,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       hazard
);

    logic [4:0] rs_eq_bits;
    logic [4:0] rt_eq_bits;
    logic       rs_match;
    logic       rt_match;
    logic       uses_rt;

    // Per-bit equality so the match reduces to a single AND tree.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_cmp
            assign rs_eq_bits[gi] = ~(rs[gi] ^ ex_rt[gi]);
            assign rt_eq_bits[gi] = ~(rt[gi] ^ ex_rt[gi]);
        end
    endgenerate

    assign rs_match = &rs_eq_bits;
    assign rt_match = &rt_eq_bits;

    // rt is a true source only for R-type, the two compare-branches and sw;
    // for I-type ALU ops and loads it is the destination.
    always_comb begin
        case (opcode)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: uses_rt = 1'b1;
            default:                         uses_rt = 1'b0;
        endcase
    end

    // $zero is never a real dependency.
    assign hazard = instr_valid & ex_mem_read & (|ex_rt) &
                    (rs_match | (uses_rt & rt_match));

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller: immediate-extension decode, load-use stall
// sequencing and taken-branch flush. Optional stall performance counter is
// built only when ID_STALL_PERF_EN is defined; otherwise stall_cycles is 0.
module id_hazard_ctrl
    import id_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int PERF_W            = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt,
    input  logic              branch_taken,
    output logic [1:0]        ext_mode,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [PERF_W-1:0] stall_cycles
);

    // Bubbles still owed after the first (Mealy) hazard cycle.
    localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);

    hz_state_e  state_reg, state_next;
    logic [1:0] cnt_reg, cnt_next;
    logic       hazard;

    load_use_detect u_detect (
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .hazard      (hazard)
    );

    assign ext_mode = decode_ext_mode(opcode);

    // Next-state: a taken branch aborts any stall; otherwise count down bubbles.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (branch_taken) begin
            state_next = ST_RUN;
            cnt_next   = 2'd0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (hazard && (LOAD_STALL_CYCLES > 1)) begin
                        state_next = ST_STALL;
                        cnt_next   = STALL_INIT;
                    end
                end
                ST_STALL: begin
                    cnt_next = cnt_reg - 2'd1;
                    if (cnt_reg == 2'd1) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    state_next = ST_RUN;
                    cnt_next   = 2'd0;
                end
            endcase
        end
    end

    // Pipeline controls; reset forces free-running defaults even if inputs
    // would otherwise signal a hazard.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (!reset) begin
            if (branch_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if ((state_reg == ST_STALL) || hazard) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    // FSM state and bubble counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_RUN;
            cnt_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

`ifdef ID_STALL_PERF_EN
    logic [PERF_W-1:0] perf_reg;

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_reg <= '0;
        end else if (!pc_write && (perf_reg != {PERF_W{1'b1}})) begin
            perf_reg <= perf_reg + 1'b1;
        end
    end

    assign stall_cycles = perf_reg;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: three instances (1, 2 and 3 bubbles per hazard,
// one with a narrow counter to reach saturation) share one stimulus stream.
module tb_id_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       branch_taken;

    logic [1:0]  ext_w [3];
    logic        pc_w  [3];
    logic        ifw_w [3];
    logic        fl_w  [3];
    logic        bub_w [3];
    logic [15:0] sc0;
    logic [2:0]  sc1;
    logic [15:0] sc2;

    int n_checks = 0;
    int n_errors = 0;
    int step_no  = 0;

    // Reference model state: bubbles still owed after the current cycle and
    // the expected performance counter value, per instance.
    int n_cfg    [3] = '{1, 2, 3};
    int perf_max [3] = '{65535, 7, 65535};
    int stall_left [3];
    int perf       [3];

    always #5 clk = ~clk;

    id_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .PERF_W(16)) dut0 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
        .rs(rs), .rt(rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .branch_taken(branch_taken), .ext_mode(ext_w[0]), .pc_write(pc_w[0]),
        .ifid_write(ifw_w[0]), .ifid_flush(fl_w[0]), .idex_bubble(bub_w[0]),
        .stall_cycles(sc0));

    id_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .PERF_W(3)) dut1 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
        .rs(rs), .rt(rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .branch_taken(branch_taken), .ext_mode(ext_w[1]), .pc_write(pc_w[1]),
        .ifid_write(ifw_w[1]), .ifid_flush(fl_w[1]), .idex_bubble(bub_w[1]),
        .stall_cycles(sc1));

    id_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .PERF_W(16)) dut2 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
        .rs(rs), .rt(rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .branch_taken(branch_taken), .ext_mode(ext_w[2]), .pc_write(pc_w[2]),
        .ifid_write(ifw_w[2]), .ifid_flush(fl_w[2]), .idex_bubble(bub_w[2]),
        .stall_cycles(sc2));

    function automatic logic [31:0] get_sc(input int i);
        if (i == 0) return {16'd0, sc0};
        if (i == 1) return {29'd0, sc1};
        return {16'd0, sc2};
    endfunction

    function automatic logic [1:0] ref_ext(input logic [5:0] op);
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return 2'b01;
        if (op == 6'h0F) return 2'b10;
        return 2'b00;
    endfunction

    // A load in EX blocks the ID instruction if it writes a register the
    // instruction reads; rt counts as read only for R-type, beq, bne, sw.
    function automatic bit ref_hazard();
        bit reads_rt;
        reads_rt = (opcode == 6'h00) || (opcode == 6'h04) ||
                   (opcode == 6'h05) || (opcode == 6'h2B);
        return instr_valid && ex_mem_read && (ex_rt != 5'd0) &&
               ((ex_rt == rs) || (reads_rt && (ex_rt == rt)));
    endfunction

    // Expected pc_write for instance i in the current cycle.
    function automatic bit ref_stalled(input int i);
        if (reset || branch_taken) return 1'b0;
        return (stall_left[i] > 0) || ref_hazard();
    endfunction

    task automatic chk(input string tag, input int idx,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    task automatic check_all();
        bit st, fl;
        for (int i = 0; i < 3; i++) begin
            st = ref_stalled(i);
            fl = !reset && branch_taken;
            chk("ext_mode", i, 32'(ext_w[i]), 32'(ref_ext(opcode)));
            chk("pc_write", i, 32'(pc_w[i]), 32'(!st));
            chk("ifid_write", i, 32'(ifw_w[i]), 32'(!st));
            chk("ifid_flush", i, 32'(fl_w[i]), 32'(fl));
            chk("idex_bubble", i, 32'(bub_w[i]), 32'(st || fl));
`ifdef ID_STALL_PERF_EN
            chk("stall_cycles", i, get_sc(i), 32'(perf[i]));
`else
            chk("stall_cycles", i, get_sc(i), 32'd0);
`endif
        end
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        bit hz;
        hz = ref_hazard();
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                stall_left[i] = 0;
                perf[i]       = 0;
            end else begin
                if (ref_stalled(i) && perf[i] < perf_max[i]) perf[i]++;
                if (branch_taken)          stall_left[i] = 0;
                else if (stall_left[i] > 0) stall_left[i]--;
                else if (hz)               stall_left[i] = n_cfg[i] - 1;
            end
        end
    endtask

    // One cycle: drive at edge+1, check at edge+4, then cross the next edge.
    task automatic step(input logic iv, input logic [5:0] op, input logic [4:0] rs_v,
                        input logic [4:0] rt_v, input logic emr, input logic [4:0] ert,
                        input logic br);
        instr_valid  = iv;
        opcode       = op;
        rs           = rs_v;
        rt           = rt_v;
        ex_mem_read  = emr;
        ex_rt        = ert;
        branch_taken = br;
        #3;
        check_all();
        $display("step %0d iv=%b op=%h rs=%0d rt=%0d ld=%b ex_rt=%0d br=%b pc_write=%b%b%b",
                 step_no, iv, op, rs_v, rt_v, emr, ert, br, pc_w[0], pc_w[1], pc_w[2]);
        step_no++;
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 6'h08, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
    endtask

    logic [5:0] op_pool [12] = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h23, 6'h08,
                                 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h3F, 6'h02};

    initial begin
        for (int i = 0; i < 3; i++) begin
            stall_left[i] = 0;
            perf[i]       = 0;
        end
        reset = 1'b1;
        instr_valid = 1'b1; opcode = 6'h00; rs = 5'd3; rt = 5'd3;
        ex_mem_read = 1'b1; ex_rt = 5'd3; branch_taken = 1'b0;
        #2;
        // Reset held with hazardous inputs: controls must stay free-running.
        check_all();
        @(posedge clk); #1; model_edge();
        check_all();
        #5;
        reset = 1'b0;
        @(posedge clk); #1; model_edge();

        // Immediate-extension decode.
        step(1'b1, 6'h0D, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
        step(1'b1, 6'h0F, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
        step(1'b1, 6'h23, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
        chk("ext_lw_const", 0, 32'(ext_w[0]), 32'd0);

        // rs load-use hazard.
        step(1'b1, 6'h23, 5'd5, 5'd9, 1'b1, 5'd5, 1'b0);
        idle(3);
`ifdef ID_STALL_PERF_EN
        chk("one_stall_const", 0, get_sc(0), 32'd1);
`endif

        // rt hazard on R-type, then addi where rt is a destination.
        step(1'b1, 6'h00, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0);
        idle(3);
        step(1'b1, 6'h08, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0);
        chk("addi_no_stall", 2, 32'(pc_w[2]), 32'd1);
        idle(1);

        // $zero never stalls; invalid instruction never stalls.
        step(1'b1, 6'h00, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        step(1'b0, 6'h00, 5'd4, 5'd4, 1'b1, 5'd4, 1'b0);
        step(1'b0, 6'h00, 5'd4, 5'd4, 1'b1, 5'd4, 1'b1);
        idle(1);

        // Branch on the second stall cycle aborts the stall.
        step(1'b1, 6'h2B, 5'd1, 5'd6, 1'b1, 5'd6, 1'b0);
        step(1'b1, 6'h2B, 5'd1, 5'd6, 1'b1, 5'd6, 1'b1);
        chk("abort_run_next", 2, 32'(stall_left[2]), 32'd0);
        idle(2);

        // Reset pulsed mid-stall.
        step(1'b1, 6'h04, 5'd8, 5'd1, 1'b1, 5'd8, 1'b0);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            stall_left[i] = 0;
            perf[i]       = 0;
        end
        check_all();
        @(posedge clk); #1; model_edge();
        reset = 1'b0;
        idle(3);

        // Randomised traffic with small register numbers to provoke hazards.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 9) != 0),
                 op_pool[$urandom_range(0, 11)],
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 7) == 0));
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
